// File: rtl/miner_host_sequencer.sv
// miner_host_sequencer: runs one mining job against core_flattened by loading midstate/work,
// stepping nonces through the barrier handshake and reporting found/exhausted/timeout.
module miner_host_sequencer #(
    parameter logic [9:0]  net_id_p         = 10'b1,
    parameter int          cmd_reg_addr_p   = 20,
    parameter int          nonce_reg_addr_p = 1,
    parameter logic [31:0] pc_data_p        = 32'h2,
    parameter logic [31:0] bar_mask_p       = 32'd7,
    parameter int          settle_cycles_p  = 2,
    parameter int          gap_cycles_p     = 2,
    parameter int          timeout_cycles_p = 65536
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [255:0] midstate_i,
    input  logic [95:0]  work_i,
    input  logic [31:0]  nonce_start_i,
    input  logic [31:0]  nonce_end_i,
    input  logic [2:0]   barrier_i,
    output logic [59:0]  net_packet_flat_o,
    output logic         busy_o,
    output logic         found_o,
    output logic [31:0]  found_nonce_o,
    output logic         exhausted_o,
    output logic         timeout_o,
    output logic [31:0]  nonces_tried_o
);
    // Packet layout: {id[59:50], op[49:47], reserved[46:42], data[41:10], addr[9:0]}.
    // Handshake: start_i is a one-cycle request honoured only in IDLE; barrier_i is a level
    // sampled only in WAIT_BAR, after the settle window has let the previous value clear.
    localparam logic [2:0] op_null_lp = 3'b000;
    localparam logic [2:0] op_reg_lp  = 3'b010;
    localparam logic [2:0] op_pc_lp   = 3'b011;
    localparam logic [2:0] op_bar_lp  = 3'b100;
    localparam int         wd_w_lp    = $clog2(timeout_cycles_p + 1);
    localparam logic [wd_w_lp-1:0] wd_last_lp  = wd_w_lp'(timeout_cycles_p - 1);
    localparam logic [7:0]         gap_last_lp = 8'(gap_cycles_p - 1);
    localparam logic [7:0]         set_last_lp = 8'(settle_cycles_p - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_BAR, S_LD_MID, S_LD_WORK, S_GAP, S_LD_NONCE,
        S_CMD, S_PC, S_NULLP, S_SETTLE, S_WAIT_BAR, S_DONE
    } state_e;

    state_e              state_q, state_n;
    logic [7:0]          cnt_q, cnt_n;
    logic [wd_w_lp-1:0]  wdog_q, wdog_n;
    logic [1:0]          cmd_q, cmd_n;
    logic [31:0]         nonce_q, nonce_n, nonce_end_q;
    logic [255:0]        mid_q;
    logic [95:0]         work_q;
    logic                load_n;
    logic                found_n, exhausted_n, timeout_n;
    logic [31:0]         found_nonce_n, tried_n;
    logic [59:0]         pkt_n;

    function automatic logic [59:0] mk(input logic [2:0] op, input logic [31:0] data,
                                       input logic [9:0] addr);
        return {net_id_p, op, 5'd0, data, addr};
    endfunction

    always_comb begin
        state_n       = state_q;
        cnt_n         = cnt_q;
        wdog_n        = wdog_q;
        cmd_n         = cmd_q;
        nonce_n       = nonce_q;
        load_n        = 1'b0;
        found_n       = found_o;
        found_nonce_n = found_nonce_o;
        exhausted_n   = exhausted_o;
        timeout_n     = timeout_o;
        tried_n       = nonces_tried_o;
        if (abort_i) begin
            state_n = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (start_i) begin
                    state_n       = S_LD_BAR;
                    load_n        = 1'b1;
                    cmd_n         = 2'd1;
                    nonce_n       = nonce_start_i;
                    found_n       = 1'b0;
                    found_nonce_n = 32'd0;
                    exhausted_n   = 1'b0;
                    timeout_n     = 1'b0;
                    tried_n       = 32'd0;
                end
                S_LD_BAR: begin
                    state_n = S_LD_MID;
                    cnt_n   = 8'd0;
                end
                S_LD_MID: if (cnt_q == 8'd7) begin
                    state_n = S_LD_WORK;
                    cnt_n   = 8'd0;
                end else cnt_n = cnt_q + 8'd1;
                S_LD_WORK: if (cnt_q == 8'd2) state_n = S_CMD;
                           else cnt_n = cnt_q + 8'd1;
                S_GAP: if (cnt_q == gap_last_lp)
                           state_n = (cmd_q == 2'd2) ? S_LD_NONCE : S_CMD;
                       else cnt_n = cnt_q + 8'd1;
                S_LD_NONCE: state_n = S_CMD;
                S_CMD:      state_n = S_PC;
                S_PC:       state_n = S_NULLP;
                S_NULLP: if (cmd_q == 2'd3) state_n = S_DONE;
                         else begin
                             state_n = S_SETTLE;
                             cnt_n   = 8'd0;
                         end
                S_SETTLE: if (cnt_q == set_last_lp) begin
                    state_n = S_WAIT_BAR;
                    wdog_n  = '0;
                end else cnt_n = cnt_q + 8'd1;
                S_WAIT_BAR: begin
                    wdog_n = wdog_q + 1'b1;
                    cnt_n  = 8'd0;
                    // nonce_q already holds nonce_start, so an LDWORK completion only advances cmd.
                    if (barrier_i == 3'b000 && cmd_q == 2'd1) begin
                        state_n = S_GAP;
                        cmd_n   = 2'd2;
                    end else if (barrier_i == 3'b000 && cmd_q == 2'd2) begin
                        state_n = S_GAP;
                        tried_n = nonces_tried_o + 32'd1;
                        if (nonce_q == nonce_end_q) begin
                            exhausted_n = 1'b1;
                            cmd_n       = 2'd3;
                        end else nonce_n = nonce_q + 32'd1;
                    end else if (barrier_i == 3'b001 && cmd_q == 2'd2) begin
                        state_n       = S_GAP;
                        found_n       = 1'b1;
                        found_nonce_n = nonce_q;
                        cmd_n         = 2'd3;
                    end else if (wdog_q == wd_last_lp) begin
                        state_n   = S_IDLE;
                        timeout_n = 1'b1;
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // The packet register is loaded with the packet belonging to the state being entered.
    always_comb begin
        pkt_n = mk(op_null_lp, 32'hFFFF_FFFE, 10'd24);
        unique case (state_n)
            S_LD_BAR:   pkt_n = mk(op_bar_lp, bar_mask_p, 10'd24);
            S_LD_MID:   pkt_n = mk(op_reg_lp, mid_q[(7 - int'(cnt_n[2:0])) * 32 +: 32],
                                   10'(cnt_n) + 10'd1);
            S_LD_WORK:  pkt_n = mk(op_reg_lp, work_q[(2 - int'(cnt_n[1:0])) * 32 +: 32],
                                   10'(cnt_n) + 10'd9);
            S_LD_NONCE: pkt_n = mk(op_reg_lp, nonce_n, 10'(nonce_reg_addr_p));
            S_CMD:      pkt_n = mk(op_reg_lp, {30'd0, cmd_n}, 10'(cmd_reg_addr_p));
            S_PC:       pkt_n = mk(op_pc_lp, pc_data_p, 10'd0);
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            cnt_q             <= 8'd0;
            wdog_q            <= '0;
            cmd_q             <= 2'd0;
            nonce_q           <= 32'd0;
            nonce_end_q       <= 32'd0;
            mid_q             <= '0;
            work_q            <= '0;
            net_packet_flat_o <= mk(op_null_lp, 32'd0, 10'd0);
            found_o           <= 1'b0;
            found_nonce_o     <= 32'd0;
            exhausted_o       <= 1'b0;
            timeout_o         <= 1'b0;
            nonces_tried_o    <= 32'd0;
        end else begin
            state_q           <= state_n;
            cnt_q             <= cnt_n;
            wdog_q            <= wdog_n;
            cmd_q             <= cmd_n;
            nonce_q           <= nonce_n;
            net_packet_flat_o <= pkt_n;
            found_o           <= found_n;
            found_nonce_o     <= found_nonce_n;
            exhausted_o       <= exhausted_n;
            timeout_o         <= timeout_n;
            nonces_tried_o    <= tried_n;
            if (load_n) begin
                mid_q       <= midstate_i;
                work_q      <= work_i;
                nonce_end_q <= nonce_end_i;
            end
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_miner_host_sequencer.sv
// Testbench for miner_host_sequencer: a barrier-driven core model plus a job-level packet
// sequence model compared against the packets the sequencer actually emits.
module tb_miner_host_sequencer;
    localparam int         PW      = 60;
    localparam int         WD      = 16;
    localparam logic [2:0] OP_NULL = 3'b000;
    localparam logic [2:0] OP_REG  = 3'b010;
    localparam logic [2:0] OP_PC   = 3'b011;
    localparam logic [2:0] OP_BAR  = 3'b100;

    logic         clk = 1'b0;
    logic         reset, start_i, abort_i;
    logic [255:0] midstate_i;
    logic [95:0]  work_i;
    logic [31:0]  nonce_start_i, nonce_end_i;
    logic [2:0]   barrier_i;
    logic [PW-1:0] net_packet_flat_o;
    logic         busy_o, found_o, exhausted_o, timeout_o;
    logic [31:0]  found_nonce_o, nonces_tried_o;

    int tests = 0;
    int fails = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    logic        mon_en = 1'b0, stuck = 1'b0, hit_en = 1'b0;
    logic [31:0] hit_nonce = 32'd0, last_nonce = 32'd0, last_cmd = 32'd0;
    int          resp_cnt = 0;

    miner_host_sequencer #(.timeout_cycles_p(WD)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .midstate_i(midstate_i), .work_i(work_i), .nonce_start_i(nonce_start_i),
        .nonce_end_i(nonce_end_i), .barrier_i(barrier_i),
        .net_packet_flat_o(net_packet_flat_o), .busy_o(busy_o), .found_o(found_o),
        .found_nonce_o(found_nonce_o), .exhausted_o(exhausted_o), .timeout_o(timeout_o),
        .nonces_tried_o(nonces_tried_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pkt(input logic [2:0] op, input logic [31:0] data,
                                         input logic [9:0] addr);
        return {10'd1, op, 5'd0, data, addr};
    endfunction

    // Core model: a PC write starts a run (barrier 010); a few cycles later it reports
    // 001 if the LDNONCE run hit the chosen nonce, otherwise 000.
    always @(negedge clk) begin
        if (!reset) begin
            if (net_packet_flat_o[49:47] != OP_NULL) begin
                if (mon_en) got_q.push_back(net_packet_flat_o);
                if (net_packet_flat_o[49:47] == OP_REG && net_packet_flat_o[9:0] == 10'd1)
                    last_nonce = net_packet_flat_o[41:10];
                if (net_packet_flat_o[49:47] == OP_REG && net_packet_flat_o[9:0] == 10'd20)
                    last_cmd = net_packet_flat_o[41:10];
                if (net_packet_flat_o[49:47] == OP_PC) begin
                    barrier_i = 3'b010;
                    resp_cnt  = $urandom_range(1, 6);
                end
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0 && !stuck)
                    barrier_i = (last_cmd == 32'd2 && hit_en && last_nonce == hit_nonce)
                                ? 3'b001 : 3'b000;
            end
        end
    end

    task automatic start_pulse(input logic [255:0] mid, input logic [95:0] wk,
                               input logic [31:0] ns, input logic [31:0] ne);
        midstate_i    = mid;
        work_i        = wk;
        nonce_start_i = ns;
        nonce_end_i   = ne;
        start_i       = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_job(input string name, input logic [255:0] mid, input logic [95:0] wk,
                           input logic [31:0] ns, input logic [31:0] ne, input logic he,
                           input logic [31:0] hn, input logic glitch);
        logic [31:0] n;
        logic [31:0] tried;
        logic        ef, ee;
        int          cyc, bad;
        exp_q.delete();
        exp_q.push_back(pkt(OP_BAR, 32'd7, 10'd24));
        for (int k = 0; k < 8; k++) exp_q.push_back(pkt(OP_REG, mid[255 - 32*k -: 32], 10'(1 + k)));
        for (int k = 0; k < 3; k++) exp_q.push_back(pkt(OP_REG, wk[95 - 32*k -: 32], 10'(9 + k)));
        exp_q.push_back(pkt(OP_REG, 32'd1, 10'd20));
        exp_q.push_back(pkt(OP_PC, 32'd2, 10'd0));
        n = ns; tried = 0; ef = 1'b0; ee = 1'b0;
        for (int guard = 0; guard < 64; guard++) begin
            exp_q.push_back(pkt(OP_REG, n, 10'd1));
            exp_q.push_back(pkt(OP_REG, 32'd2, 10'd20));
            exp_q.push_back(pkt(OP_PC, 32'd2, 10'd0));
            if (he && n == hn) begin ef = 1'b1; break; end
            tried++;
            if (n == ne) begin ee = 1'b1; break; end
            n = n + 32'd1;
        end
        exp_q.push_back(pkt(OP_REG, 32'd3, 10'd20));
        exp_q.push_back(pkt(OP_PC, 32'd2, 10'd0));

        got_q.delete();
        hit_en = he; hit_nonce = hn; mon_en = 1'b1;
        start_pulse(mid, wk, ns, ne);
        cyc = 0;
        while (busy_o && cyc < 3000) begin
            if (glitch && cyc == 2) begin
                midstate_i    = {8{$urandom()}};
                work_i        = {3{$urandom()}};
                nonce_start_i = $urandom();
                nonce_end_i   = $urandom();
                start_i       = 1'b1;
            end else start_i = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        mon_en  = 1'b0;
        tests++;
        if (busy_o) begin
            fails++;
            $display("FAIL %s_done: busy_o still %b after %0d cycles, required 0", name, busy_o, cyc);
        end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s_count: %0d packets seen, required %0d", name, got_q.size(), exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s_seq: packet %0d is %h, required %h", name, bad, got_q[bad], exp_q[bad]);
        end
        tests++;
        if ({found_o, exhausted_o, timeout_o} !== {ef, ee, 1'b0}) begin
            fails++;
            $display("FAIL %s_flags: found/exh/tmo %b%b%b, required %b%b0", name,
                     found_o, exhausted_o, timeout_o, ef, ee);
        end
        tests++;
        if (nonces_tried_o !== tried) begin
            fails++;
            $display("FAIL %s_tried: %0d, required %0d", name, nonces_tried_o, tried);
        end
        tests++;
        if (found_nonce_o !== (ef ? hn : 32'd0)) begin
            fails++;
            $display("FAIL %s_found_nonce: %h, required %h", name, found_nonce_o, ef ? hn : 32'd0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; barrier_i = 3'b000;
        midstate_i = '0; work_i = '0; nonce_start_i = '0; nonce_end_i = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (net_packet_flat_o !== pkt(OP_NULL, 32'd0, 10'd0) || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_pkt: pkt %h busy %b, required %h busy 0", net_packet_flat_o,
                     busy_o, pkt(OP_NULL, 32'd0, 10'd0));
        end
        tests++;
        if ({found_o, exhausted_o, timeout_o} !== 3'b000 || found_nonce_o !== 0 || nonces_tried_o !== 0) begin
            fails++;
            $display("FAIL reset_flags: f/e/t %b%b%b nonce %h tried %0d, required all 0",
                     found_o, exhausted_o, timeout_o, found_nonce_o, nonces_tried_o);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (net_packet_flat_o !== pkt(OP_NULL, 32'hFFFF_FFFE, 10'd24)) begin
            fails++;
            $display("FAIL idle_pkt: %h, required %h", net_packet_flat_o, pkt(OP_NULL, 32'hFFFF_FFFE, 10'd24));
        end
    endtask

    task automatic test_load();
        logic [255:0] mid;
        logic [95:0]  wk;
        logic [PW-1:0] want;
        int cyc;
        mid = {32'h56f6950a, 32'h86a3a529, 32'h7961969c, 32'h7bfdb28c,
               32'h54c9af5a, 32'h951237b8, 32'h7979d96f, 32'hc01823e1};
        wk  = {32'ha24c2683, 32'hcf1beb52, 32'h2cf50119};
        hit_en = 1'b0;
        start_pulse(mid, wk, 32'd7, 32'd7);
        for (int k = 1; k <= 15; k++) begin
            if (k == 1)       want = pkt(OP_BAR, 32'd7, 10'd24);
            else if (k <= 9)  want = pkt(OP_REG, mid[255 - 32*(k-2) -: 32], 10'(k - 1));
            else if (k <= 12) want = pkt(OP_REG, wk[95 - 32*(k-10) -: 32], 10'(k - 1));
            else if (k == 13) want = pkt(OP_REG, 32'd1, 10'd20);
            else if (k == 14) want = pkt(OP_PC, 32'd2, 10'd0);
            else              want = pkt(OP_NULL, 32'hFFFF_FFFE, 10'd24);
            tests++;
            if (net_packet_flat_o !== want || busy_o !== 1'b1) begin
                fails++;
                $display("FAIL load_t+%0d: pkt %h busy %b, required %h busy 1", k,
                         net_packet_flat_o, busy_o, want);
            end
            if (k < 15) @(negedge clk);
        end
        cyc = 0;
        while (busy_o && cyc < 500) begin @(negedge clk); cyc++; end
        tests++;
        if (busy_o !== 1'b0 || exhausted_o !== 1'b1 || nonces_tried_o !== 32'd1 || found_o !== 1'b0) begin
            fails++;
            $display("FAIL load_end: busy %b exh %b tried %0d found %b, required 0 1 1 0",
                     busy_o, exhausted_o, nonces_tried_o, found_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] ns;
        int len;
        for (int j = 0; j < 4; j++) begin
            ns  = $urandom();
            len = $urandom_range(0, 4);
            run_job($sformatf("rand%0d", j), {8{$urandom()}}, {3{$urandom()}}, ns, ns + 32'(len),
                    1'($urandom_range(0, 1)), ns + 32'($urandom_range(0, len + 1)), 1'b0);
        end
    endtask

    task automatic test_watchdog();
        stuck = 1'b1;
        start_pulse({8{32'h1234_5678}}, {3{32'h9abc_def0}}, 32'd0, 32'd10);
        repeat (32) @(negedge clk);
        tests++;
        if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL wdog_before: busy %b timeout %b at t+33, required 1 0", busy_o, timeout_o);
        end
        @(negedge clk);
        tests++;
        if (busy_o !== 1'b0 || timeout_o !== 1'b1 ||
            net_packet_flat_o !== pkt(OP_NULL, 32'hFFFF_FFFE, 10'd24)) begin
            fails++;
            $display("FAIL wdog_fire: busy %b timeout %b pkt %h at t+34, required 0 1 idle",
                     busy_o, timeout_o, net_packet_flat_o);
        end
        stuck = 1'b0;
    endtask

    task automatic test_abort();
        start_pulse({8{32'hdead_beef}}, {3{32'h0bad_f00d}}, 32'd0, 32'd3);
        repeat (4) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        got_q.delete();
        mon_en = 1'b1;
        tests++;
        if (busy_o !== 1'b0 || net_packet_flat_o !== pkt(OP_NULL, 32'hFFFF_FFFE, 10'd24)) begin
            fails++;
            $display("FAIL abort_next: busy %b pkt %h at t+6, required 0 idle", busy_o, net_packet_flat_o);
        end
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        tests++;
        if (got_q.size() != 0 || exhausted_o !== 1'b0 || found_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet: %0d packets exh %b found %b, required 0 0 0",
                     got_q.size(), exhausted_o, found_o);
        end
    endtask

    task automatic test_reset_mid();
        stuck = 1'b1;
        start_pulse({8{32'h0f0f_0f0f}}, {3{32'hf0f0_f0f0}}, 32'd1, 32'd9);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (net_packet_flat_o !== pkt(OP_NULL, 32'd0, 10'd0) || busy_o !== 1'b0 ||
            timeout_o !== 1'b0 || nonces_tried_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid: pkt %h busy %b tmo %b tried %0d, required reset values",
                     net_packet_flat_o, busy_o, timeout_o, nonces_tried_o);
        end
        reset = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        run_job("hit", {8{32'h1111_2222}}, {3{32'h3333_4444}}, 32'h0, 32'hFF, 1'b1, 32'd3, 1'b0);
        run_job("exhaust", {8{32'h5555_6666}}, {3{32'h7777_8888}}, 32'd5, 32'd6, 1'b0, 32'd0, 1'b0);
        run_job("wrap", {8{32'habcd_0123}}, {3{32'h4567_89ab}}, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'd0, 1'b0);
        test_random();
        run_job("start_busy", {8{32'h2468_ace0}}, {3{32'h1357_9bdf}}, 32'h20, 32'h21, 1'b0, 32'd0, 1'b1);
        test_watchdog();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
